transmitter: RTL and testbench

- Slow-control (SC) serializer for the MAROC front-end ASIC.
- Captures the full 829-bit MAROC configuration word from parallel inputs when started.
- Pulses the ASIC SC reset, then shifts the word out LSB-first on D_SC_out with a gated serial clock CK_SC_out.
- Sits between the board configuration registers and the MAROC SC pins.

---
 rtl/transmitter.sv | 176 +++++++++++++++++
 tb/tb_transmitter.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/transmitter.sv
`timescale 1ns/1ps
// Purpose : MAROC slow-control serializer; captures the 829-bit configuration word,
//           pulses RSTn_SC_out, then shifts the word out LSB-first with a gated clock.
// Latency : start edge -> RST (RST_CYCLES cycles) -> first data bit; frame = FRAME_LEN SHIFT cycles.
// Backpr. : none; start_in is a level request sampled only in IDLE, ignored while busy.
//
// Ports:
//   clk_in, reset_in (async, active-low), start_in
//   configuration fields *_in         -> packed into the frame (bit 0 = ON_OFF_otabg_in)
//   D_SC_out    serial data (frame bit 0 first)
//   RSTn_SC_out active-low ASIC slow-control reset
//   CK_SC_out   serial clock, ~clk_in while shifting, else 0
//   state_out   FSM state (0 IDLE, 1 RST, 2 SHIFT, 3 DONE)
module transmitter #(
   parameter int FRAME_LEN  = 829,
   parameter int RST_CYCLES = 2
) (
   input  logic         clk_in,
   input  logic         reset_in,
   input  logic         start_in,
   input  logic         ON_OFF_otabg_in,
   input  logic         ON_OFF_dac_in,
   input  logic         small_dac_in,
   input  logic [9:0]   DAC2_in,
   input  logic [9:0]   DAC1_in,
   input  logic         enb_outADC_in,
   input  logic         inv_startCmptGray_in,
   input  logic         ramp_8bit_in,
   input  logic         ramp_10bit_in,
   input  logic [127:0] mask_OR_ch_in,
   input  logic         cmd_CK_mux_in,
   input  logic         d1_d2_in,
   input  logic         inv_discriADC_in,
   input  logic         polar_discri_in,
   input  logic         Enb_tristate_in,
   input  logic         valid_dc_fsb2_in,
   input  logic         sw_fsb2_50f_in,
   input  logic         sw_fsb2_100f_in,
   input  logic         sw_fsb2_100k_in,
   input  logic         sw_fsb2_50k_in,
   input  logic         valid_dc_fs_in,
   input  logic         cmd_fsb_fsu_in,
   input  logic         sw_fsb1_50f_in,
   input  logic         sw_fsb1_100f_in,
   input  logic         sw_fsb1_100k_in,
   input  logic         sw_fsb1_50k_in,
   input  logic         sw_fsu_100k_in,
   input  logic         sw_fsu_50k_in,
   input  logic         sw_fsu_25k_in,
   input  logic         sw_fsu_40f_in,
   input  logic         sw_fsu_20f_in,
   input  logic         H1H2_choice_in,
   input  logic         EN_ADC_in,
   input  logic         sw_ss_1200f_in,
   input  logic         sw_ss_600f_in,
   input  logic         sw_ss_300f_in,
   input  logic         ON_OFF_ss_in,
   input  logic         swb_buf_2p_in,
   input  logic         swb_buf_1p_in,
   input  logic         swb_buf_500f_in,
   input  logic         swb_buf_250f_in,
   input  logic         cmd_fsb_in,
   input  logic         cmd_ss_in,
   input  logic         cmd_fsu_in,
   input  logic [575:0] GAIN_in,
   input  logic [63:0]  Ctest_ch_in,
   output logic         D_SC_out,
   output logic         RSTn_SC_out,
   output logic         CK_SC_out,
   output logic [1:0]   state_out
);

   localparam int CNT_W = $clog2(FRAME_LEN);
   localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
   localparam logic [CNT_W-1:0] SHIFT_LAST = CNT_W'(FRAME_LEN - 1);
   localparam logic [CNT_W-1:0] RST_LAST   = CNT_W'(RST_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RST   = 2'd1,
      SHIFT = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t                 state_q;
   logic [FRAME_LEN-1:0]   sr_q;
   logic [CNT_W-1:0]       cnt_q;
   logic                   d_q;
   logic                   rstn_q;
   logic [FRAME_LEN-1:0]   frame_w;

   // Frame map, MSB first: bit 0 (ON_OFF_otabg) sits at the right end.
   assign frame_w = {
      Ctest_ch_in,                                               // [828:765]
      GAIN_in,                                                   // [764:189]
      cmd_fsu_in, cmd_ss_in, cmd_fsb_in,                         // [188:186]
      swb_buf_250f_in, swb_buf_500f_in, swb_buf_1p_in,
      swb_buf_2p_in,                                             // [185:182]
      ON_OFF_ss_in, sw_ss_300f_in, sw_ss_600f_in,
      sw_ss_1200f_in,                                            // [181:178]
      EN_ADC_in, H1H2_choice_in,                                 // [177:176]
      sw_fsu_20f_in, sw_fsu_40f_in, sw_fsu_25k_in,
      sw_fsu_50k_in, sw_fsu_100k_in,                             // [175:171]
      sw_fsb1_50k_in, sw_fsb1_100k_in, sw_fsb1_100f_in,
      sw_fsb1_50f_in,                                            // [170:167]
      cmd_fsb_fsu_in, valid_dc_fs_in,                            // [166:165]
      sw_fsb2_50k_in, sw_fsb2_100k_in, sw_fsb2_100f_in,
      sw_fsb2_50f_in,                                            // [164:161]
      valid_dc_fsb2_in, Enb_tristate_in, polar_discri_in,
      inv_discriADC_in, d1_d2_in, cmd_CK_mux_in,                 // [160:155]
      mask_OR_ch_in,                                             // [154:27]
      ramp_10bit_in, ramp_8bit_in, inv_startCmptGray_in,
      enb_outADC_in,                                             // [26:23]
      DAC1_in,                                                   // [22:13]
      DAC2_in,                                                   // [12:3]
      small_dac_in, ON_OFF_dac_in, ON_OFF_otabg_in               // [2:0]
   };

   // cnt_q counts RST cycles, then is reused as the SHIFT bit index.
   // d_q is loaded one edge ahead with the bit the ASIC will see next.
   always_ff @(posedge clk_in or negedge reset_in) begin
      if (!reset_in) begin
         state_q <= IDLE;
         sr_q    <= '0;
         cnt_q   <= '0;
         d_q     <= 1'b0;
         rstn_q  <= 1'b1;
      end else begin
         case (state_q)
            IDLE: begin
               if (start_in) begin
                  sr_q    <= frame_w;
                  cnt_q   <= '0;
                  rstn_q  <= 1'b0;
                  state_q <= RST;
               end
            end
            RST: begin
               if (cnt_q == RST_LAST) begin
                  cnt_q   <= '0;
                  rstn_q  <= 1'b1;
                  d_q     <= sr_q[0];
                  state_q <= SHIFT;
               end else begin
                  cnt_q <= cnt_q + CNT_ONE;
               end
            end
            SHIFT: begin
               sr_q <= {1'b0, sr_q[FRAME_LEN-1:1]};
               if (cnt_q == SHIFT_LAST) begin
                  cnt_q   <= '0;
                  d_q     <= 1'b0;
                  state_q <= DONE;
               end else begin
                  cnt_q <= cnt_q + CNT_ONE;
                  d_q   <= sr_q[1];
               end
            end
            DONE: begin
               d_q     <= 1'b0;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign D_SC_out    = d_q;
   assign RSTn_SC_out = rstn_q;
   assign state_out   = state_q;

   // State only changes on rising clk_in, when ~clk_in is already low, so this
   // gate cannot produce a runt pulse; its rising edge lands mid-bit.
   assign CK_SC_out = (state_q == SHIFT) & ~clk_in;

endmodule

// File: tb/tb_transmitter.sv
`timescale 1ns/1ps
module tb_transmitter;

   logic clk_in = 1'b0;
   always #5 clk_in = ~clk_in;

   logic         reset_in = 1'b0;
   logic         start_in = 1'b0;
   logic [2:0]   lo_bits;      // frame [2:0]
   logic [9:0]   DAC2_in, DAC1_in;
   logic [3:0]   mid_bits;     // frame [26:23]
   logic [127:0] mask_OR_ch_in;
   logic [33:0]  sb;           // frame [188:155], sb[i] = frame bit 155+i
   logic [575:0] GAIN_in;
   logic [63:0]  Ctest_ch_in;
   logic         D_SC_out, RSTn_SC_out, CK_SC_out;
   logic [1:0]   state_out;

   transmitter dut (
      .clk_in(clk_in), .reset_in(reset_in), .start_in(start_in),
      .ON_OFF_otabg_in(lo_bits[0]), .ON_OFF_dac_in(lo_bits[1]), .small_dac_in(lo_bits[2]),
      .DAC2_in(DAC2_in), .DAC1_in(DAC1_in),
      .enb_outADC_in(mid_bits[0]), .inv_startCmptGray_in(mid_bits[1]),
      .ramp_8bit_in(mid_bits[2]), .ramp_10bit_in(mid_bits[3]),
      .mask_OR_ch_in(mask_OR_ch_in),
      .cmd_CK_mux_in(sb[0]), .d1_d2_in(sb[1]), .inv_discriADC_in(sb[2]),
      .polar_discri_in(sb[3]), .Enb_tristate_in(sb[4]), .valid_dc_fsb2_in(sb[5]),
      .sw_fsb2_50f_in(sb[6]), .sw_fsb2_100f_in(sb[7]), .sw_fsb2_100k_in(sb[8]),
      .sw_fsb2_50k_in(sb[9]), .valid_dc_fs_in(sb[10]), .cmd_fsb_fsu_in(sb[11]),
      .sw_fsb1_50f_in(sb[12]), .sw_fsb1_100f_in(sb[13]), .sw_fsb1_100k_in(sb[14]),
      .sw_fsb1_50k_in(sb[15]), .sw_fsu_100k_in(sb[16]), .sw_fsu_50k_in(sb[17]),
      .sw_fsu_25k_in(sb[18]), .sw_fsu_40f_in(sb[19]), .sw_fsu_20f_in(sb[20]),
      .H1H2_choice_in(sb[21]), .EN_ADC_in(sb[22]), .sw_ss_1200f_in(sb[23]),
      .sw_ss_600f_in(sb[24]), .sw_ss_300f_in(sb[25]), .ON_OFF_ss_in(sb[26]),
      .swb_buf_2p_in(sb[27]), .swb_buf_1p_in(sb[28]), .swb_buf_500f_in(sb[29]),
      .swb_buf_250f_in(sb[30]), .cmd_fsb_in(sb[31]), .cmd_ss_in(sb[32]),
      .cmd_fsu_in(sb[33]),
      .GAIN_in(GAIN_in), .Ctest_ch_in(Ctest_ch_in),
      .D_SC_out(D_SC_out), .RSTn_SC_out(RSTn_SC_out),
      .CK_SC_out(CK_SC_out), .state_out(state_out)
   );

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string nm, input int act, input int exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
   endtask

   // Scoreboard: expected serial bits, pushed when a frame is launched.
   logic exp_q[$];
   logic exp_bit;
   int   shift_cnt, rst_low, done_cnt, ck_edges;

   always @(negedge clk_in) begin
      if (reset_in === 1'b1) begin
         if (state_out == 2'd2) begin
            shift_cnt++;
            if (exp_q.size() == 0) begin
               check("extra_shift_bit", shift_cnt, 0);
            end else begin
               exp_bit = exp_q.pop_front();
               check($sformatf("bit%0d", shift_cnt - 1), int'(D_SC_out), int'(exp_bit));
            end
         end
         if (!RSTn_SC_out) rst_low++;
         if (state_out == 2'd3) begin
            done_cnt++;
            check("done_d_low", int'(D_SC_out), 0);
         end
      end
   end

   always @(posedge CK_SC_out) begin
      if (reset_in === 1'b1) begin
         ck_edges++;
         check("ck_only_in_shift", int'(state_out), 2);
      end
   end

   // Spread a frame vector across the ports using the documented bit map.
   task automatic drive(input logic [828:0] f);
      lo_bits       = f[2:0];
      DAC2_in       = f[12:3];
      DAC1_in       = f[22:13];
      mid_bits      = f[26:23];
      mask_OR_ch_in = f[154:27];
      sb            = f[188:155];
      GAIN_in       = f[764:189];
      Ctest_ch_in   = f[828:765];
   endtask

   function automatic logic [828:0] rand_frame();
      logic [828:0] f;
      for (int i = 0; i < 829; i++) f[i] = 1'($urandom_range(0, 1));
      return f;
   endfunction

   // mode 0: plain frame; 1: start pulse + GAIN change near bit 100; 2: reset near bit 400
   task automatic run_frame(input logic [828:0] f, input string nm, input int mode);
      bit disturbed = 0;
      bit aborted   = 0;
      drive(f);
      exp_q.delete();
      for (int i = 0; i < 829; i++) exp_q.push_back(f[i]);
      shift_cnt = 0; rst_low = 0; done_cnt = 0; ck_edges = 0;
      @(negedge clk_in); start_in = 1'b1;
      @(negedge clk_in); start_in = 1'b0;
      #1 check({nm, "_enter_rst"}, int'(state_out), 1);
      check({nm, "_rstn_low"}, int'(RSTn_SC_out), 0);
      for (int k = 0; k < 1200 && !(done_cnt > 0 && state_out == 2'd0) && !aborted; k++) begin
         @(negedge clk_in); #2;
         if (mode == 1 && !disturbed && shift_cnt >= 100) begin
            start_in = 1'b1;
            for (int j = 0; j < 18; j++) GAIN_in[j*32 +: 32] = $urandom();
            disturbed = 1;
            @(negedge clk_in); #2 start_in = 1'b0;
         end
         if (mode == 2 && shift_cnt >= 400) begin
            reset_in = 1'b0;
            #1;
            check({nm, "_abort_state"}, int'(state_out), 0);
            check({nm, "_abort_d"},     int'(D_SC_out), 0);
            check({nm, "_abort_rstn"},  int'(RSTn_SC_out), 1);
            check({nm, "_abort_ck"},    int'(CK_SC_out), 0);
            exp_q.delete();
            @(negedge clk_in); reset_in = 1'b1;
            aborted = 1;
         end
      end
      if (mode != 2) begin
         check({nm, "_completed"}, int'(done_cnt > 0 && state_out == 2'd0), 1);
         check({nm, "_shift_len"}, shift_cnt, 829);
         check({nm, "_rst_cycles"}, rst_low, 2);
         check({nm, "_ck_edges"}, ck_edges, 829);
         check({nm, "_done_len"}, done_cnt, 1);
         check({nm, "_bits_left"}, exp_q.size(), 0);
         repeat (5) @(negedge clk_in);
         check({nm, "_stays_idle"}, int'(state_out), 0);
      end
   endtask

   typedef struct {
      string        name;
      logic [828:0] frame;  // also the expected serial bit sequence, bit 0 first
      int           mode;
   } vec_t;

   vec_t tbl[7];

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      logic [828:0] f;
      f = '0; f[0]   = 1'b1; tbl[0] = '{"bit0_only",      f, 0};
      f = '0; f[828] = 1'b1; tbl[1] = '{"bit828_only",    f, 0};
      tbl[2] = '{"random_a", rand_frame(), 0};
      f = '1;                tbl[3] = '{"all_ones",       f, 0};
      tbl[4] = '{"start_in_shift", rand_frame(), 1};
      tbl[5] = '{"reset_mid",      rand_frame(), 2};
      tbl[6] = '{"after_reset",    rand_frame(), 0};

      drive('0);
      repeat (3) @(negedge clk_in);
      check("reset_state", int'(state_out), 0);
      check("reset_d",     int'(D_SC_out), 0);
      check("reset_rstn",  int'(RSTn_SC_out), 1);
      check("reset_ck",    int'(CK_SC_out), 0);
      reset_in = 1'b1;
      repeat (2) @(negedge clk_in);
      check("idle_no_start", int'(state_out), 0);

      for (int v = 0; v < 7; v++) run_frame(tbl[v].frame, tbl[v].name, tbl[v].mode);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
